breakbeam_emulator: RTL
=======================

BREAKBEAM_EMULATOR -- requirements
Module: breakbeam_emulator

Interface
REQ-001 SHALL have parameters: PERIOD_BITS, default 28, width of period/counter fields; PULSE_BITS, default 16, width of pulse-width field; THETA_BITS, default 6, angle index width.
REQ-002 SHALL have ports, in order:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accept; constant 1 except while reset is high.
- cfg_period  in  PERIOD_BITS  target clocks per revolution.
- cfg_pulse_width  in  PULSE_BITS  beam-high clocks per revolution.
- cfg_step  in  PERIOD_BITS  max period change per revolution; 0 means jump immediately.
- beam_out  out  1  emulated debounced break-beam signal.
- rev_strobe  out  1  one-cycle pulse at each revolution start.
- true_theta  out  THETA_BITS  exact angle index, floor(count*2^THETA_BITS/cur_period).
- cur_period  out  PERIOD_BITS  period of the revolution in progress.
- running  out  1  high when state is not IDLE.

Function
REQ-003 SHALL implement states IDLE, RUN and STOP; all outputs are registered.
REQ-004 SHALL capture the target period, pulse width and step on any cycle where cfg_valid and cfg_ready are both high.
REQ-005 SHALL clamp a captured period below 2^THETA_BITS up to 2^THETA_BITS.
REQ-006 SHALL clamp the effective pulse width to cur_period-1; a pulse width of 0 means beam_out never rises.
REQ-007 IDLE: SHALL hold count, true_theta, beam_out and rev_strobe at 0; cur_period tracks the clamped target.
REQ-008 IDLE with enable=1 at cycle N: SHALL be in RUN at N+1 with count=0, rev_strobe=1 and beam_out=(pw>0).
REQ-009 RUN/STOP: count SHALL increment by 1 per clock and wrap to 0 after cur_period-1; rev_strobe=1 exactly on cycles where count=0.
REQ-010 SHALL drive beam_out=1 exactly on cycles where count<pw (pw is the effective width).
REQ-011 SHALL produce true_theta with a fractional accumulator: acc += 2^THETA_BITS each clock; when acc >= cur_period, subtract cur_period and increment true_theta. Accumulator and true_theta SHALL both be 0 at count=0. No divider is allowed.
REQ-012 At wrap (count=cur_period-1, RUN), next cur_period SHALL be:
- the target, if cfg_step=0 or |target-cur_period| <= step;
- otherwise cur_period ± step, moving toward the target.
REQ-013 A config accepted in the same cycle as a wrap SHALL NOT affect that wrap's period computation; it applies from the next wrap.
REQ-014 enable=0 in RUN SHALL move to STOP. STOP completes the current revolution unchanged, then at wrap goes to IDLE with beam_out=0; no new rev_strobe is issued.
REQ-015 enable reasserted during STOP SHALL return to RUN with no gap in counting.
REQ-016 Period arithmetic SHALL saturate; no wrap-around of PERIOD_BITS values is allowed.

Reset
REQ-017 While reset=1, the next-cycle state SHALL be IDLE with all of the following at 0: count, acc, true_theta, beam_out, rev_strobe, running, cfg_ready.
REQ-018 Reset SHALL set the stored config to period=2^THETA_BITS, pw=0, step=0, and cur_period=2^THETA_BITS.
REQ-019 Reset asserted mid-revolution SHALL abort the revolution with beam_out low on the next cycle; enable after reset SHALL behave per REQ-008.

Verification
REQ-020 Config period=640, pw=10, step=0, then enable: beam_out high on cycles 0..9 of each revolution; rev_strobe every 640 cycles; true_theta increments every 10 cycles and reaches 63 at count 630.
REQ-021 Running at 1000, then target 700 with step 100: successive revolution lengths are 1000, 900, 800, 700, 700.
REQ-022 cfg_period=10 with pw=200 -> cur_period=64; beam_out high on counts 0..62 and low at count 63.
REQ-023 Drop enable at count 300 of a 640 revolution -> beam continues to count 639, then IDLE; running=0; no further rev_strobe.
REQ-024 Reset at count 5 while beam_out=1 -> next cycle beam_out=0, true_theta=0, running=0; enable afterwards restarts at count 0 with period 64.
REQ-025 cfg_valid with period=500 on the wrap cycle of a 640 revolution (step=0) -> next revolution is 640; the one after is 500.

Source files
------------

// File: rtl/breakbeam_emulator.sv
// breakbeam_emulator
//   Emulates a debounced break-beam sensor on a rotating shaft. A revolution
//   lasts cur_period clocks. The beam is high for the first pw clocks of each
//   revolution. An exact angle index is produced alongside it. Period changes
//   are slew-limited to cfg_step per revolution.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   enable           run request (drop to finish the current revolution and idle)
//   cfg_valid/ready  config handshake; ready is 1 except while reset is high
//   cfg_period       target clocks per revolution (clamped to >= 2^THETA_BITS)
//   cfg_pulse_width  beam-high clocks per revolution (0 = beam never rises)
//   cfg_step         max period change per revolution (0 = jump immediately)
//   beam_out         emulated beam signal
//   rev_strobe       one-cycle pulse on the first cycle of each revolution
//   true_theta       floor(count * 2^THETA_BITS / cur_period)
//   cur_period       period of the revolution in progress
//   running          high whenever the emulator is not idle
module breakbeam_emulator #(
  parameter int PERIOD_BITS = 28,
  parameter int PULSE_BITS  = 16,
  parameter int THETA_BITS  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  input  logic [PULSE_BITS-1:0]  cfg_pulse_width,
  input  logic [PERIOD_BITS-1:0] cfg_step,
  output logic                   beam_out,
  output logic                   rev_strobe,
  output logic [THETA_BITS-1:0]  true_theta,
  output logic [PERIOD_BITS-1:0] cur_period,
  output logic                   running
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam int CMP_BITS = (PERIOD_BITS > PULSE_BITS) ? PERIOD_BITS : PULSE_BITS;

  // Shortest legal period: one clock per angle step.
  localparam logic [PERIOD_BITS-1:0] MIN_PERIOD = PERIOD_BITS'(1) << THETA_BITS;

  logic [1:0]             state;
  logic [PERIOD_BITS-1:0] count;
  logic [PERIOD_BITS-1:0] acc;
  logic [PERIOD_BITS-1:0] tgt_period;
  logic [PULSE_BITS-1:0]  tgt_pw;
  logic [PERIOD_BITS-1:0] tgt_step;

  logic [1:0]             state_n;
  logic [PERIOD_BITS-1:0] count_n;
  logic [PERIOD_BITS-1:0] acc_n;
  logic [THETA_BITS-1:0]  theta_n;
  logic [PERIOD_BITS-1:0] period_n;
  logic                   run_n;
  logic                   strobe_n;
  logic                   beam_n;

  logic                   cfg_fire;
  logic [PERIOD_BITS-1:0] cfg_period_clamped;
  logic                   wrap;
  logic [PERIOD_BITS-1:0] ramp_period;
  logic [PERIOD_BITS-1:0] ramp_diff;
  logic [PERIOD_BITS:0]   ramp_sum;
  logic [PERIOD_BITS:0]   acc_sum;
  logic [CMP_BITS-1:0]    pw_limit;
  logic [CMP_BITS-1:0]    pw_eff;

  assign cfg_fire           = cfg_valid && cfg_ready;
  assign cfg_period_clamped = (cfg_period < MIN_PERIOD) ? MIN_PERIOD : cfg_period;
  assign wrap               = (count == cur_period - 1'b1);

  // Slew-limited period for the next revolution. Uses the stored target only,
  // so a config accepted on the wrap cycle waits for the following wrap.
  always_comb begin
    ramp_diff   = (tgt_period >= cur_period) ? (tgt_period - cur_period)
                                             : (cur_period - tgt_period);
    ramp_sum    = {1'b0, cur_period} + {1'b0, tgt_step};
    ramp_period = tgt_period;
    if (tgt_step != '0 && ramp_diff > tgt_step) begin
      if (tgt_period > cur_period) begin
        ramp_period = ramp_sum[PERIOD_BITS] ? '1 : ramp_sum[PERIOD_BITS-1:0];
      end else begin
        ramp_period = (tgt_step >= cur_period) ? MIN_PERIOD : (cur_period - tgt_step);
      end
    end
  end

  // Next-cycle state; all outputs are registered from these values so that
  // beam/strobe/theta line up with the count they describe.
  always_comb begin
    state_n  = state;
    count_n  = count;
    acc_n    = acc;
    theta_n  = true_theta;
    period_n = cur_period;
    acc_sum  = {1'b0, acc} + {1'b0, MIN_PERIOD};

    case (state)
      ST_IDLE: begin
        count_n  = '0;
        acc_n    = '0;
        theta_n  = '0;
        period_n = tgt_period;
        if (enable) begin
          state_n = ST_RUN;
        end
      end
      default: begin
        if (wrap) begin
          count_n = '0;
          acc_n   = '0;
          theta_n = '0;
          if (enable) begin
            state_n  = ST_RUN;
            period_n = ramp_period;
          end else begin
            state_n  = ST_IDLE;
            period_n = tgt_period;
          end
        end else begin
          count_n = count + 1'b1;
          // Fractional angle accumulator: period >= 2^THETA_BITS guarantees
          // at most one subtraction per clock.
          if (acc_sum >= {1'b0, cur_period}) begin
            acc_n   = PERIOD_BITS'(acc_sum - {1'b0, cur_period});
            theta_n = true_theta + 1'b1;
          end else begin
            acc_n = acc_sum[PERIOD_BITS-1:0];
          end
          state_n = enable ? ST_RUN : ST_STOP;
        end
      end
    endcase

    run_n    = (state_n != ST_IDLE);
    strobe_n = run_n && (count_n == '0);
    pw_limit = CMP_BITS'(period_n - 1'b1);
    pw_eff   = (CMP_BITS'(tgt_pw) > pw_limit) ? pw_limit : CMP_BITS'(tgt_pw);
    beam_n   = run_n && (CMP_BITS'(count_n) < pw_eff);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      acc        <= '0;
      true_theta <= '0;
      beam_out   <= 1'b0;
      rev_strobe <= 1'b0;
      running    <= 1'b0;
      cfg_ready  <= 1'b0;
      tgt_period <= MIN_PERIOD;
      tgt_pw     <= '0;
      tgt_step   <= '0;
      cur_period <= MIN_PERIOD;
    end else begin
      cfg_ready <= 1'b1;
      if (cfg_fire) begin
        tgt_period <= cfg_period_clamped;
        tgt_pw     <= cfg_pulse_width;
        tgt_step   <= cfg_step;
      end
      state      <= state_n;
      count      <= count_n;
      acc        <= acc_n;
      true_theta <= theta_n;
      cur_period <= period_n;
      beam_out   <= beam_n;
      rev_strobe <= strobe_n;
      running    <= run_n;
    end
  end

endmodule
